// File: rtl/crossing_debounce.sv
`default_nettype none
// ============================================================================
// Module      : crossing_debounce
// Description : Debounces the per-frame zebra-crossing detector result into a
//               stable decision and emits rise/fall edge events through a
//               one-deep valid/ready holding register.
//               Optional statistics (frame counter, peak white count) are
//               built only when CROSSING_DEBOUNCE_STATS_EN is defined.
// Ports       : clk, rst (async, active-high)
//               det_valid / det_crossing / det_white_count : detector input
//               crossing_stable : debounced decision (registered)
//               evt_valid / evt_ready / evt_rise : edge event handshake
//               evt_overflow    : sticky, an event was dropped
//               frame_count / peak_white : statistics (0 without the macro)
// Revision    : 1.0 - initial release
// ============================================================================
module crossing_debounce #(
    parameter int IMG_WIDTH      = 320,
    parameter int IMG_HEIGHT     = 240,
    parameter int CONFIRM_FRAMES = 3,
    parameter int RELEASE_FRAMES = 5,
    parameter int MIN_WHITE      = 100,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       det_valid,
    input  logic                                       det_crossing,
    input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]    det_white_count,
    output logic                                       crossing_stable,
    output logic                                       evt_valid,
    input  logic                                       evt_ready,
    output logic                                       evt_rise,
    output logic                                       evt_overflow,
    output logic [15:0]                                frame_count,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]    peak_white
);

    localparam int CW     = $clog2(IMG_WIDTH*IMG_HEIGHT);
    localparam int MAX_FR = (CONFIRM_FRAMES > RELEASE_FRAMES) ? CONFIRM_FRAMES : RELEASE_FRAMES;
    localparam int CNT_W  = $clog2(MAX_FR + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0]     C_MIN_WHITE = CW'(MIN_WHITE);
    localparam logic [CNT_W-1:0]  C_CONFIRM   = CNT_W'(CONFIRM_FRAMES);
    localparam logic [CNT_W-1:0]  C_RELEASE   = CNT_W'(RELEASE_FRAMES);
    localparam logic [IDLE_W-1:0] C_TIMEOUT   = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ASSERTED  = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_hit_cnt, w_hit_nxt;
    logic [CNT_W-1:0]   r_miss_cnt, w_miss_nxt;
    logic [IDLE_W-1:0]  r_idle;
    logic               r_stable;
    logic               r_evt_valid, r_evt_rise, r_evt_overflow;
    logic               w_hit, w_timeout, w_evt_gen, w_evt_rise;

    assign w_hit     = det_valid && det_crossing && (det_white_count >= C_MIN_WHITE);
    // A frame arriving in the same cycle as the timeout wins: the timeout
    // is only considered when det_valid is low.
    assign w_timeout = (r_idle == C_TIMEOUT) && !det_valid;

    // ------------------------------------------------------------------
    // Idle counter: cycles since the last det_valid, saturating.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (det_valid) begin
            r_idle <= '0;
        end else if (r_idle != C_TIMEOUT) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_stable   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hit_cnt  <= w_hit_nxt;
            r_miss_cnt <= w_miss_nxt;
            r_stable   <= (w_state_nxt == ST_ASSERTED) || (w_state_nxt == ST_RELEASING);
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and event generation
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = r_hit_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_evt_gen   = 1'b0;
        w_evt_rise  = 1'b0;
        if (det_valid) begin
            case (r_state)
                ST_CLEAR: begin
                    if (w_hit) begin
                        if (CONFIRM_FRAMES == 1) begin
                            w_state_nxt = ST_ASSERTED;
                            w_evt_gen   = 1'b1;
                            w_evt_rise  = 1'b1;
                        end else begin
                            w_state_nxt = ST_ARMING;
                            w_hit_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_ARMING: begin
                    if (w_hit) begin
                        if ((r_hit_cnt + CNT_W'(1)) == C_CONFIRM) begin
                            w_state_nxt = ST_ASSERTED;
                            w_hit_nxt   = '0;
                            w_evt_gen   = 1'b1;
                            w_evt_rise  = 1'b1;
                        end else begin
                            w_hit_nxt = r_hit_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_CLEAR;
                        w_hit_nxt   = '0;
                    end
                end
                ST_ASSERTED: begin
                    if (!w_hit) begin
                        if (RELEASE_FRAMES == 1) begin
                            w_state_nxt = ST_CLEAR;
                            w_evt_gen   = 1'b1;
                        end else begin
                            w_state_nxt = ST_RELEASING;
                            w_miss_nxt  = CNT_W'(1);
                        end
                    end
                end
                ST_RELEASING: begin
                    if (!w_hit) begin
                        if ((r_miss_cnt + CNT_W'(1)) == C_RELEASE) begin
                            w_state_nxt = ST_CLEAR;
                            w_miss_nxt  = '0;
                            w_evt_gen   = 1'b1;
                        end else begin
                            w_miss_nxt = r_miss_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_ASSERTED;
                        w_miss_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_CLEAR;
                    w_hit_nxt   = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end else if (w_timeout) begin
            case (r_state)
                ST_ASSERTED, ST_RELEASING: begin
                    w_state_nxt = ST_CLEAR;
                    w_miss_nxt  = '0;
                    w_evt_gen   = 1'b1;
                end
                ST_ARMING: begin
                    w_state_nxt = ST_CLEAR;
                    w_hit_nxt   = '0;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-deep event holding register. A new event may replace the
    // pending one only when that one is being accepted in the same cycle;
    // otherwise the new event is dropped and the overflow flag sticks.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_valid    <= 1'b0;
            r_evt_rise     <= 1'b0;
            r_evt_overflow <= 1'b0;
        end else if (w_evt_gen) begin
            if (!r_evt_valid || evt_ready) begin
                r_evt_valid <= 1'b1;
                r_evt_rise  <= w_evt_rise;
            end else begin
                r_evt_overflow <= 1'b1;
            end
        end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign crossing_stable = r_stable;
    assign evt_valid       = r_evt_valid;
    assign evt_rise        = r_evt_rise;
    assign evt_overflow    = r_evt_overflow;

`ifdef CROSSING_DEBOUNCE_STATS_EN
    logic [15:0]   r_frame_count;
    logic [CW-1:0] r_peak_white;
    logic          w_enter_asserted;
    logic          w_in_asserted;

    assign w_enter_asserted = ((r_state == ST_CLEAR) || (r_state == ST_ARMING))
                              && (w_state_nxt == ST_ASSERTED);
    assign w_in_asserted    = (r_state == ST_ASSERTED) || (r_state == ST_RELEASING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
            r_peak_white  <= '0;
        end else begin
            if (det_valid) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_enter_asserted) begin
                r_peak_white <= det_white_count;
            end else if (w_in_asserted && w_hit && (det_white_count > r_peak_white)) begin
                r_peak_white <= det_white_count;
            end
        end
    end

    assign frame_count = r_frame_count;
    assign peak_white  = r_peak_white;
`else
    assign frame_count = '0;
    assign peak_white  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crossing_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_crossing_debounce
// Description : Self-checking bench for crossing_debounce. Directed scenarios
//               followed by randomized frames, gaps, back-pressure and
//               resets, compared each cycle against a frame-level model.
//               Statistics outputs are modelled when
//               CROSSING_DEBOUNCE_STATS_EN is defined, else expected 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crossing_debounce;

    localparam int CONFIRM = 3;
    localparam int RELEASE = 5;
    localparam int MINW    = 100;
    localparam int TMO     = 1000;
    localparam int CW      = $clog2(320*240);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          det_valid = 1'b0;
    logic          det_crossing = 1'b0;
    logic [CW-1:0] det_white_count = '0;
    logic          evt_ready = 1'b0;
    logic          crossing_stable, evt_valid, evt_rise, evt_overflow;
    logic [15:0]   frame_count;
    logic [CW-1:0] peak_white;

    crossing_debounce #(
        .IMG_WIDTH      (320),
        .IMG_HEIGHT     (240),
        .CONFIRM_FRAMES (CONFIRM),
        .RELEASE_FRAMES (RELEASE),
        .MIN_WHITE      (MINW),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .det_valid       (det_valid),
        .det_crossing    (det_crossing),
        .det_white_count (det_white_count),
        .crossing_stable (crossing_stable),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_rise        (evt_rise),
        .evt_overflow    (evt_overflow),
        .frame_count     (frame_count),
        .peak_white      (peak_white)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference: a decision flag plus the length of the current
    // run of frames that disagree with it, and the idle gap length.
    bit            m_stable;
    int            m_run;
    int            m_idle;
    bit            m_pend, m_rise, m_ovf;
    logic [15:0]   m_frames;
    logic [CW-1:0] m_peak;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stable = 0; m_run = 0; m_idle = 0;
        m_pend = 0; m_rise = 0; m_ovf = 0;
        m_frames = '0; m_peak = '0;
    endtask

    task automatic model_update(input bit v, input bit c, input logic [CW-1:0] w, input bit rdy);
        bit ev  = 0;
        bit er  = 0;
        bit hit = v && c && (int'(w) >= MINW);
        bit was = m_stable;
        if (v) begin
            m_frames = m_frames + 16'd1;
            if (hit == m_stable) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run >= (m_stable ? RELEASE : CONFIRM)) begin
                    m_stable = !m_stable;
                    m_run = 0;
                    ev = 1;
                    er = m_stable;
                end
            end
            if (hit && m_stable) begin
                if (!was) m_peak = w;
                else if (w > m_peak) m_peak = w;
            end
            m_idle = 0;
        end else begin
            if (m_idle >= TMO) begin
                if (m_stable) begin
                    m_stable = 0;
                    ev = 1;
                    er = 0;
                end
                m_run = 0;
            end
            if (m_idle < TMO) m_idle++;
        end
        if (ev) begin
            if (!m_pend || rdy) begin
                m_pend = 1;
                m_rise = er;
            end else begin
                m_ovf = 1;
            end
        end else if (m_pend && rdy) begin
            m_pend = 0;
        end
    endtask

    task automatic compare_all();
        check("stable", {31'd0, crossing_stable}, {31'd0, m_stable});
        check("evt_valid", {31'd0, evt_valid}, {31'd0, m_pend});
        if (m_pend) check("evt_rise", {31'd0, evt_rise}, {31'd0, m_rise});
        check("overflow", {31'd0, evt_overflow}, {31'd0, m_ovf});
`ifdef CROSSING_DEBOUNCE_STATS_EN
        check("frame_count", {16'd0, frame_count}, {16'd0, m_frames});
        check("peak_white", 32'(peak_white), 32'(m_peak));
`else
        check("frame_count", {16'd0, frame_count}, 32'd0);
        check("peak_white", 32'(peak_white), 32'd0);
`endif
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled
    // 1 time unit after the following rising edge.
    task automatic step(input bit v, input bit c, input logic [CW-1:0] w, input bit rdy);
        det_valid       = v;
        det_crossing    = c;
        det_white_count = w;
        evt_ready       = rdy;
        @(posedge clk);
        model_update(v, c, w, rdy);
        #1;
        compare_all();
    endtask

    task automatic frame(input bit c, input int w, input bit rdy);
        step(1'b1, c, CW'(w), rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy);
    endtask

    // Reset asserted between edges: outputs must clear before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_stable", {31'd0, crossing_stable}, 32'd0);
        check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_evt_rise", {31'd0, evt_rise}, 32'd0);
        check("rst_overflow", {31'd0, evt_overflow}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_peak", 32'(peak_white), 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit mode;
        int bias;
        model_reset();
        #3;
        check("reset_stable", {31'd0, crossing_stable}, 32'd0);
        check("reset_evt_valid", {31'd0, evt_valid}, 32'd0);
        check("reset_overflow", {31'd0, evt_overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three hits assert one cycle after the third frame, one rise event.
        frame(1, 150, 1); idle(1, 1);
        frame(1, 150, 1); idle(1, 1);
        frame(1, 150, 1);
        check("d_rise_stable", {31'd0, crossing_stable}, 32'd1);
        check("d_rise_valid", {31'd0, evt_valid}, 32'd1);
        check("d_rise_dir", {31'd0, evt_rise}, 32'd1);
        idle(1, 1);
        check("d_rise_accepted", {31'd0, evt_valid}, 32'd0);

        // Four misses, one hit, five misses: release on the tenth frame.
        for (int i = 0; i < 4; i++) frame(0, 150, 1);
        frame(1, 150, 1);
        for (int i = 0; i < 4; i++) frame(0, 150, 1);
        check("d_rel_hold", {31'd0, crossing_stable}, 32'd1);
        frame(0, 150, 1);
        check("d_rel_stable", {31'd0, crossing_stable}, 32'd0);
        check("d_rel_fall", {31'd0, evt_valid & ~evt_rise}, 32'd1);
        idle(1, 1);

        // Interrupted arming never asserts.
        do_reset();
        frame(1, 150, 1); frame(1, 150, 1); frame(0, 150, 1);
        frame(1, 150, 1); frame(1, 150, 1);
        check("d_intr_stable", {31'd0, crossing_stable}, 32'd0);
        check("d_intr_evt", {31'd0, evt_valid}, 32'd0);

        // White count just below / exactly at the threshold.
        do_reset();
        frame(1, 99, 1);
        check("d_w99_stable", {31'd0, crossing_stable}, 32'd0);
        frame(1, 100, 1); frame(1, 100, 1); frame(1, 100, 1);
        check("d_w100_stable", {31'd0, crossing_stable}, 32'd1);
        idle(1, 1);

        // A frame landing exactly at the timeout wins; then a real timeout.
        idle(999, 1);
        frame(0, 150, 1);
        check("d_tmo_prio", {31'd0, crossing_stable}, 32'd1);
        check("d_tmo_prio_evt", {31'd0, evt_valid}, 32'd0);
        frame(1, 150, 1);
        idle(1000, 1);
        check("d_tmo_before", {31'd0, crossing_stable}, 32'd1);
        idle(1, 1);
        check("d_tmo_stable", {31'd0, crossing_stable}, 32'd0);
        check("d_tmo_fall", {31'd0, evt_valid & ~evt_rise}, 32'd1);

        // Back-pressure: fall event dropped, rise kept, overflow sticky.
        do_reset();
        for (int i = 0; i < 3; i++) frame(1, 150, 0);
        for (int i = 0; i < 5; i++) frame(0, 150, 0);
        check("d_ovf_rise_held", {31'd0, evt_valid & evt_rise}, 32'd1);
        check("d_ovf_flag", {31'd0, evt_overflow}, 32'd1);
        do_reset();

        // New event coincident with accept replaces the pending one.
        for (int i = 0; i < 3; i++) frame(1, 150, 0);
        for (int i = 0; i < 4; i++) frame(0, 150, 0);
        frame(0, 150, 1);
        check("d_swap_valid", {31'd0, evt_valid}, 32'd1);
        check("d_swap_fall", {31'd0, evt_rise}, 32'd0);
        check("d_swap_ovf", {31'd0, evt_overflow}, 32'd0);

        // Randomized phase.
        do_reset();
        mode = 0;
        bias = 70;
        for (int n = 0; n < 4000; n++) begin
            int gap, sel, w;
            bit c;
            if ($urandom_range(0, 14) == 0) mode = !mode;
            if ($urandom_range(0, 49) == 0) bias = (bias == 70) ? 10 : 70;
            gap = ($urandom_range(0, 299) == 0) ? int'($urandom_range(995, 1005))
                                                : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'b0, '0, ($urandom_range(0, 99) < bias));
            sel = $urandom_range(0, 9);
            if (sel < 6)      w = $urandom_range(120, 200);
            else if (sel < 8) w = $urandom_range(98, 101);
            else              w = $urandom_range(0, 76799);
            c = mode ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 15);
            frame(c, w, ($urandom_range(0, 99) < bias));
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
